// File: rtl/hit_ctrl.sv
// hit_ctrl: player health / invincibility sequencer.
// Hit requests from the monsters are arbitrated lowest index first. Each
// charged hit costs one health point and opens a fixed invincibility window.
// Losing the last point ends the game until restart or reset.
// Optional feature macro: DAMAGE_BLINK_EN. When defined, the sprite blinks
// during the invincibility window. When undefined, the sprite is always shown.
module hit_ctrl #(
    parameter int HIT_SRC       = 2,
    parameter int HEALTH_W      = 4,
    parameter int HEALTH_INIT   = 3,
    parameter int HEALTH_MAX    = 9,
    parameter int INVULN_CYCLES = 300_000_000,
    parameter int BLINK_SHIFT   = 22
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [HIT_SRC-1:0]  i_hit_req,
    input  logic                i_heal,
    input  logic                i_restart,
    output logic [HEALTH_W-1:0] o_health,
    output logic                o_invuln,
    output logic                o_dead,
    output logic [HIT_SRC-1:0]  o_hit_ack,
    output logic                o_visible
);

    localparam int CW = $clog2(INVULN_CYCLES);
    localparam logic [CW-1:0]       CNT_LOAD = CW'(INVULN_CYCLES - 1);
    localparam logic [HEALTH_W-1:0] H_INIT   = HEALTH_W'(HEALTH_INIT);
    localparam logic [HEALTH_W-1:0] H_MAX    = HEALTH_W'(HEALTH_MAX);
    localparam logic [HEALTH_W-1:0] H_ONE    = HEALTH_W'(1);

    typedef enum logic [1:0] {
        S_ALIVE  = 2'd0,
        S_INVULN = 2'd1,
        S_DEAD   = 2'd2
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [HEALTH_W-1:0] r_health, w_health_nxt;
    logic [CW-1:0]       r_cnt,    w_cnt_nxt;
    logic [HIT_SRC-1:0]  r_ack,    w_ack_nxt;
    logic [HIT_SRC-1:0]  w_grant;
    logic [HEALTH_W-1:0] w_health_inc;

    // Isolate the lowest set request bit (two's-complement trick).
    assign w_grant      = i_hit_req & (~i_hit_req + HIT_SRC'(1));
    assign w_health_inc = (r_health < H_MAX) ? r_health + H_ONE : r_health;

    // Next-state, health, window counter and ack selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_health_nxt = r_health;
        w_cnt_nxt    = r_cnt;
        w_ack_nxt    = '0;
        if (i_restart) begin
            w_state_nxt  = S_ALIVE;
            w_health_nxt = H_INIT;
            w_cnt_nxt    = '0;
        end else begin
            case (r_state)
                S_ALIVE: begin
                    if (|i_hit_req) begin
                        // A simultaneous heal is dropped in favour of the hit.
                        w_ack_nxt = w_grant;
                        if (r_health <= H_ONE) begin
                            w_health_nxt = '0;
                            w_state_nxt  = S_DEAD;
                        end else begin
                            w_health_nxt = r_health - H_ONE;
                            w_state_nxt  = S_INVULN;
                            w_cnt_nxt    = CNT_LOAD;
                        end
                    end else if (i_heal) begin
                        w_health_nxt = w_health_inc;
                    end
                end
                S_INVULN: begin
                    if (i_heal)
                        w_health_nxt = w_health_inc;
                    if (r_cnt == '0)
                        w_state_nxt = S_ALIVE;
                    else
                        w_cnt_nxt = r_cnt - CW'(1);
                end
                S_DEAD: begin
                    w_health_nxt = '0;
                end
                default: begin
                    // Unreachable encoding: recover to ALIVE, keep health.
                    w_state_nxt = S_ALIVE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_ALIVE;
            r_health <= H_INIT;
            r_cnt    <= '0;
            r_ack    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_health <= w_health_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    assign o_health  = r_health;
    assign o_invuln  = (r_state == S_INVULN);
    assign o_dead    = (r_state == S_DEAD);
    assign o_hit_ack = r_ack;

`ifdef DAMAGE_BLINK_EN
    logic [BLINK_SHIFT:0] r_blink;
    logic                 w_enter_inv;

    assign w_enter_inv = (w_state_nxt == S_INVULN) && (r_state != S_INVULN);

    // Free-running blink phase, zeroed on every window entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_enter_inv)
            r_blink <= '0;
        else
            r_blink <= r_blink + 1'b1;
    end

    assign o_visible = (r_state == S_INVULN) ? r_blink[BLINK_SHIFT] : 1'b1;
`else
    assign o_visible = 1'b1;
`endif

endmodule
